// File: rtl/mcycle_ctrl.sv
// Multi-cycle execute-unit scheduler: dispatches to divider/clmul/fpu, tracks
// completion, kill draining and timeout. Define FPU_SCHED_EN to enable the fpu path.
module mcycle_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_unit,
  input  logic        kill,
  input  logic        div_ready,
  input  logic        clmul_ready,
  input  logic        fpu_ready,
  input  logic [31:0] div_result,
  input  logic [31:0] clmul_result,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        div_enable,
  output logic        clmul_enable,
  output logic        fpu_enable,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  flags,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  unit_q, unit_d;
  logic [6:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0] result_q, result_d, unit_result;
  logic [4:0]  flags_q, flags_d, unit_flags;
  logic        legal, unit_ready, timeout;
  logic [2:0]  en;
  logic        stall_c, done_c, error_c;

  always_comb begin
    legal       = (req_unit != 2'd3);
    unit_ready  = 1'b0;
    unit_result = '0;
    unit_flags  = '0;
`ifdef FPU_SCHED_EN
    case (unit_q)
      2'd0:    begin unit_ready = div_ready;   unit_result = div_result;   end
      2'd1:    begin unit_ready = clmul_ready; unit_result = clmul_result; end
      2'd2:    begin unit_ready = fpu_ready;   unit_result = fpu_result;
                     unit_flags = fpu_flags;                               end
      default: ;
    endcase
`else
    legal = legal && (req_unit != 2'd2);
    case (unit_q)
      2'd0:    begin unit_ready = div_ready;   unit_result = div_result;   end
      2'd1:    begin unit_ready = clmul_ready; unit_result = clmul_result; end
      default: ;
    endcase
`endif
    cnt_inc = (cnt_q == 7'(TIMEOUT)) ? cnt_q : cnt_q + 7'd1;
    // Compared against the incremented value so the error lands TIMEOUT-1 cycles after enable
    timeout = (cnt_inc == 7'(TIMEOUT - 1)) && !unit_ready;
  end

  always_comb begin
    state_d  = state_q;
    unit_d   = unit_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    en       = '0;
    stall_c  = 1'b0;
    done_c   = 1'b0;
    error_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !kill) begin
          if (legal) begin
            en[req_unit] = 1'b1;
            unit_d       = req_unit;
            cnt_d        = '0;
            stall_c      = 1'b1;
            state_d      = BUSY;
          end else begin
            error_c = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_inc;
        if (unit_ready) begin
          if (kill) begin
            state_d = IDLE;
          end else begin
            result_d = unit_result;
            flags_d  = unit_flags;
            state_d  = DONE;
          end
        end else if (kill) begin
          state_d = DRAIN;
        end else if (timeout) begin
          error_c = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        done_c  = !kill;
        state_d = IDLE;
      end
      DRAIN: begin
        stall_c = req_valid;
        cnt_d   = cnt_inc;
        if (unit_ready) begin
          state_d = IDLE;
        end else if (timeout) begin
          error_c = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      unit_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      unit_q   <= unit_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Combinational outputs are forced low while reset is held
  assign div_enable   = rst & en[0];
  assign clmul_enable = rst & en[1];
  assign stall        = rst & stall_c;
  assign done         = rst & done_c;
  assign error        = rst & error_c;
  assign result       = result_q;

`ifdef FPU_SCHED_EN
  assign fpu_enable = rst & en[2];
  assign flags      = flags_q;
`else
  logic unused_fpu;
  assign unused_fpu = ^{fpu_ready, fpu_result, fpu_flags, en[2], flags_q};
  assign fpu_enable = 1'b0;
  assign flags      = '0;
`endif

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl: dispatch/latency, kill/drain, illegal unit,
// timeout and asynchronous reset behaviour.
module tb_mcycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_unit;
  logic        kill;
  logic        div_ready, clmul_ready, fpu_ready;
  logic [31:0] div_result, clmul_result, fpu_result;
  logic [4:0]  fpu_flags;
  logic        div_enable, clmul_enable, fpu_enable;
  logic        stall, done, error;
  logic [31:0] result;
  logic [4:0]  flags;

  int checks = 0;
  int errors = 0;

  mcycle_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_unit(req_unit), .kill(kill),
    .div_ready(div_ready), .clmul_ready(clmul_ready), .fpu_ready(fpu_ready),
    .div_result(div_result), .clmul_result(clmul_result), .fpu_result(fpu_result),
    .fpu_flags(fpu_flags), .div_enable(div_enable), .clmul_enable(clmul_enable),
    .fpu_enable(fpu_enable), .stall(stall), .done(done), .result(result),
    .flags(flags), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    div_ready   = 1'b0;
    clmul_ready = 1'b0;
    fpu_ready   = 1'b0;
    kill        = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b1; req_unit = 2'd0; kill = 1'b0;
    div_ready = 1'b0; clmul_ready = 1'b0; fpu_ready = 1'b0;
    div_result = '0; clmul_result = '0; fpu_result = '0; fpu_flags = '0;
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_den", div_enable, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    nxt();

    // div op, ready at cycle 5, stray clmul_ready at cycle 2
    req_valid = 1'b1; req_unit = 2'd0;
    smp(); chk("div_en_c0", div_enable, 1); chk("div_stall_c0", stall, 1);
    nxt();
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) clmul_ready = 1'b1;
      smp(); chk("div_stall_busy", stall, 1); chk("div_done_busy", done, 0);
      chk("div_en_busy", div_enable, 0);
      nxt();
    end
    div_ready = 1'b1; div_result = 32'h2A;
    smp(); chk("div_stall_c5", stall, 1); chk("div_done_c5", done, 0);
    nxt();
    smp(); chk("div_done_c6", done, 1); chk("div_stall_c6", stall, 0);
    chk("div_result_c6", result, 32'h2A); chk("div_en_c6", div_enable, 0);
    chk("div_flags_c6", flags, 0);
    nxt();
    req_valid = 1'b0;
    smp(); chk("div_done_c7", done, 0); chk("div_hold_c7", result, 32'h2A);
    nxt();

`ifdef FPU_SCHED_EN
    req_valid = 1'b1; req_unit = 2'd2;
    smp(); chk("fpu_en_c0", fpu_enable, 1); chk("fpu_stall_c0", stall, 1);
    nxt(); nxt(); nxt();
    fpu_ready = 1'b1; fpu_flags = 5'b00001; fpu_result = 32'h3F80_0000;
    smp(); chk("fpu_stall_c3", stall, 1);
    nxt();
    smp(); chk("fpu_done_c4", done, 1); chk("fpu_flags_c4", flags, 5'h01);
    chk("fpu_result_c4", result, 32'h3F80_0000);
    nxt();
    req_valid = 1'b0;
    smp(); nxt();
`else
    req_valid = 1'b1; req_unit = 2'd2; fpu_flags = 5'h1F;
    smp(); chk("fpu_illegal_err", error, 1); chk("fpu_illegal_en", fpu_enable, 0);
    chk("fpu_illegal_stall", stall, 0);
    nxt();
    req_valid = 1'b0;
    smp(); chk("fpu_illegal_err_off", error, 0);
    nxt();
`endif

    // clmul op: flags must read 0 even with fpu activity on the inputs
    req_valid = 1'b1; req_unit = 2'd1;
    smp(); chk("clm_en_c0", clmul_enable, 1);
    nxt();
    clmul_ready = 1'b1; clmul_result = 32'h55; fpu_ready = 1'b1; fpu_flags = 5'h1F;
    smp(); nxt();
    smp(); chk("clm_done", done, 1); chk("clm_result", result, 32'h55);
    chk("clm_flags", flags, 0);
    nxt();
    req_valid = 1'b0;
    smp(); nxt();

    // kill during BUSY -> DRAIN, new clmul request held off until div_ready retires
    req_valid = 1'b1; req_unit = 2'd0;
    smp(); chk("drn_den_c0", div_enable, 1);
    nxt(); nxt();
    kill = 1'b1;
    smp(); chk("drn_stall_c2", stall, 1);
    nxt();
    req_unit = 2'd1;
    for (int c = 3; c <= 8; c++) begin
      if (c == 5) clmul_ready = 1'b1;
      if (c == 8) begin div_ready = 1'b1; div_result = 32'hDEAD; end
      smp(); chk("drn_stall", stall, 1); chk("drn_cen", clmul_enable, 0);
      chk("drn_done", done, 0);
      nxt();
    end
    smp(); chk("drn_cen_c9", clmul_enable, 1); chk("drn_stall_c9", stall, 1);
    chk("drn_result_c9", result, 32'h55);
    nxt();
    clmul_ready = 1'b1; clmul_result = 32'h77;
    smp(); nxt();
    smp(); chk("drn_clm_done", done, 1); chk("drn_clm_result", result, 32'h77);
    nxt();
    req_valid = 1'b0;
    smp(); nxt();

    // kill and ready in the same BUSY cycle: back to IDLE with no done
    req_valid = 1'b1; req_unit = 2'd0;
    smp(); nxt();
    div_ready = 1'b1; div_result = 32'hBAD; kill = 1'b1;
    smp(); nxt();
    req_valid = 1'b0;
    smp(); chk("kr_done", done, 0); chk("kr_stall", stall, 0);
    chk("kr_result", result, 32'h77);
    nxt();

    // illegal unit
    req_valid = 1'b1; req_unit = 2'd3;
    smp(); chk("ill_err", error, 1); chk("ill_den", div_enable, 0);
    chk("ill_cen", clmul_enable, 0); chk("ill_stall", stall, 0);
    nxt();
    req_valid = 1'b0;
    smp(); chk("ill_err_off", error, 0);
    nxt();

    // timeout: clmul never answers
    req_valid = 1'b1; req_unit = 2'd1;
    smp(); chk("to_cen", clmul_enable, 1);
    nxt();
    for (int c = 1; c <= 63; c++) begin
      smp(); chk("to_err", error, (c == 63) ? 1 : 0); chk("to_stall", stall, 1);
      chk("to_done", done, 0);
      nxt();
    end
    req_valid = 1'b0;
    smp(); chk("to_idle_stall", stall, 0); chk("to_idle_err", error, 0);
    nxt();
    clmul_ready = 1'b1;
    smp(); nxt();
    smp(); chk("to_late_done", done, 0);
    nxt();

    // asynchronous reset mid-BUSY
    req_valid = 1'b1; req_unit = 2'd0;
    smp(); chk("ar_den", div_enable, 1);
    nxt();
    div_result = 32'h99;
    #2; rst = 1'b0; #1;
    chk("ar_stall", stall, 0); chk("ar_done", done, 0); chk("ar_den0", div_enable, 0);
    chk("ar_result", result, 0); chk("ar_error", error, 0); chk("ar_flags", flags, 0);
    req_valid = 1'b0;
    #1; rst = 1'b1;
    nxt();
    div_ready = 1'b1;
    smp(); chk("ar_late_stall", stall, 0); chk("ar_late_done0", done, 0);
    nxt();
    smp(); chk("ar_late_done1", done, 0); chk("ar_late_result", result, 0);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Ports: clk  in  1  rising-edge clock.
REQ-003 Ports: rst  in  1  asynchronous active-low reset.
REQ-004 Ports: req_valid  in  1  execute-stage multi-cycle op present; held until done.
REQ-005 Ports: req_unit  in  2  0=divider, 1=clmul, 2=fpu, 3=illegal.
REQ-006 Ports: kill  in  1  pipeline clear; abandon current op.
REQ-007 Ports: div_ready, clmul_ready, fpu_ready  in  1 each  unit result valid, one-cycle pulse.
REQ-008 Ports: div_result, clmul_result, fpu_result  in  32 each  unit results.
REQ-009 Ports: fpu_flags  in  5  IEEE exception flags.
REQ-010 Ports: div_enable, clmul_enable, fpu_enable  out  1 each  one-cycle start pulse.
REQ-011 Ports: stall  out  1  hold execute stage.
REQ-012 Ports: done  out  1  result valid this cycle.
REQ-013 Ports: result  out  32  registered result.
REQ-014 Ports: flags  out  5  registered fpu flags; 0 for non-fpu ops.
REQ-015 Ports: error  out  1  one-cycle pulse on illegal unit or timeout.
REQ-016 Parameter: TIMEOUT, default 64, maximum cycles from enable to ready.

Function
REQ-017 SHALL implement states IDLE, BUSY, DONE, DRAIN, held in a registered state variable.
REQ-018 IDLE, req_valid=1, kill=0, legal unit: pulse the selected enable for exactly one cycle, latch req_unit, clear the timeout counter, go to BUSY.
REQ-019 IDLE, req_unit=3: no enable, error=1 for one cycle, stay IDLE.
REQ-020 BUSY, ready of the latched unit seen: register that unit's result (and flags when fpu, else 0), go to DONE.
REQ-021 SHALL ignore ready pulses from non-latched units in all states.
REQ-022 DONE: done=1, stall=0, go to IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-023 stall SHALL be the combinational value (req_valid & state==IDLE & ~kill & legal unit) | state==BUSY | (state==DRAIN & req_valid).
REQ-024 Latency: enable in cycle 0, ready in cycle N, done in cycle N+1.
REQ-025 BUSY with kill=1 and no ready in the same cycle: go to DRAIN and discard the result.
REQ-026 BUSY with kill=1 and ready in the same cycle: go to IDLE with done=0.
REQ-027 DRAIN: wait for the latched unit's ready, then go to IDLE; kill in DRAIN has no effect.
REQ-028 kill in IDLE or DONE: suppress enable and done, go to or stay in IDLE.
REQ-029 Timeout counter: 7 bits, increments each cycle in BUSY or DRAIN, saturates at TIMEOUT.
REQ-030 Counter reaching TIMEOUT-1 without ready: error=1, go to IDLE, done=0.
REQ-031 result and flags SHALL hold their values except when written in REQ-020.

Reset
REQ-032 rst=0 SHALL immediately force state=IDLE, counter=0, result=0, flags=0, and all enables, done, error=0.
REQ-033 stall SHALL read 0 during reset regardless of req_valid.
REQ-034 Reset mid-operation abandons the op; a late ready after reset is ignored in IDLE.

Configuration
REQ-035 Macro FPU_SCHED_EN defined: unit 2 is legal and the fpu path operates as specified.
REQ-036 Macro FPU_SCHED_EN undefined: unit 2 is treated as illegal (REQ-019), fpu_enable is tied 0, flags is constant 0, and the fpu inputs are unused.

Verification
REQ-037 Div request, div_ready at cycle 5 with result 0x0000002A -> div_enable pulse at cycle 0, stall cycles 0-5, done=1 with result 0x2A at cycle 6.
REQ-038 Fpu request, ready at cycle 3 with flags 5'b00001 -> flags=0x01 on done; a following clmul op -> flags=0.
REQ-039 Div started, kill at cycle 2, div_ready at cycle 8 -> DRAIN, no done; a new clmul request is stalled until cycle 9, then clmul_enable pulses.
REQ-040 req_unit=3 -> error pulse, no enable, stall=0; clmul request with no ready for 64 cycles -> error at cycle 63, IDLE.
REQ-041 rst asserted asynchronously mid-BUSY -> outputs 0 before the next edge; a div_ready pulse after release -> no done.
